// File: rtl/adder_axi_master.sv
// AXI4-Lite master that sequences one add on the memory-mapped adder peripheral:
// write operand A, write operand B, read the sum, read the overflow flag.
module adder_axi_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned ADDR_OPA   = 0,
  parameter int unsigned ADDR_OPB   = 4,
  parameter int unsigned ADDR_SUM   = 8,
  parameter int unsigned ADDR_OVF   = 12,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                    m1_axi_aclk,
  input  logic                    m1_axi_areset,

  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [DATA_WIDTH-1:0]   sum,
  output logic                    overflow,
  output logic [3:0]              resp_flags,

  output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
  output logic                    m1_axi_awvalid,
  input  logic                    m1_axi_awready,
  output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
  output logic                    m1_axi_wvalid,
  input  logic                    m1_axi_wready,
  input  logic                    m1_axi_bresp,
  input  logic                    m1_axi_bvalid,
  output logic                    m1_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
  output logic                    m1_axi_arvalid,
  input  logic                    m1_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
  input  logic                    m1_axi_rresp,
  input  logic                    m1_axi_rvalid,
  output logic                    m1_axi_rready
);

  localparam logic [ADDR_WIDTH-1:0] A_OPA = ADDR_WIDTH'(ADDR_OPA);
  localparam logic [ADDR_WIDTH-1:0] A_OPB = ADDR_WIDTH'(ADDR_OPB);
  localparam logic [ADDR_WIDTH-1:0] A_SUM = ADDR_WIDTH'(ADDR_SUM);
  localparam logic [ADDR_WIDTH-1:0] A_OVF = ADDR_WIDTH'(ADDR_OVF);

  // The counter only ever holds 0..TIMEOUT-1; reaching TIMEOUT is detected combinationally.
  localparam int unsigned   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_A,
    S_RESP_A,
    S_WR_B,
    S_RESP_B,
    S_RD_SUM,
    S_RD_OVF,
    S_DONE,
    S_ERR
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   opa_q, opa_d;
  logic [DATA_WIDTH-1:0]   opb_q, opb_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    ar_done_q, ar_done_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   sum_q, sum_d;
  logic                    ovf_q, ovf_d;
  logic [3:0]              resp_q, resp_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, expired;

  // Bus outputs are decoded from registered state only, so no valid ever depends on a ready.
  always_comb begin
    m1_axi_awaddr  = '0;
    m1_axi_awvalid = 1'b0;
    m1_axi_wdata   = '0;
    m1_axi_wvalid  = 1'b0;
    m1_axi_bready  = 1'b0;
    m1_axi_araddr  = '0;
    m1_axi_arvalid = 1'b0;
    m1_axi_rready  = 1'b0;
    unique case (state_q)
      S_WR_A: begin
        m1_axi_awaddr  = A_OPA;
        m1_axi_wdata   = opa_q;
        m1_axi_awvalid = !aw_done_q;
        m1_axi_wvalid  = !w_done_q;
      end
      S_WR_B: begin
        m1_axi_awaddr  = A_OPB;
        m1_axi_wdata   = opb_q;
        m1_axi_awvalid = !aw_done_q;
        m1_axi_wvalid  = !w_done_q;
      end
      S_RESP_A, S_RESP_B: m1_axi_bready = 1'b1;
      S_RD_SUM: begin
        m1_axi_araddr  = A_SUM;
        m1_axi_arvalid = !ar_done_q;
        m1_axi_rready  = ar_done_q;
      end
      S_RD_OVF: begin
        m1_axi_araddr  = A_OVF;
        m1_axi_arvalid = !ar_done_q;
        m1_axi_rready  = ar_done_q;
      end
      default: ;
    endcase
  end

  assign m1_axi_wstrb = '1;

  assign aw_hs  = m1_axi_awvalid && m1_axi_awready;
  assign w_hs   = m1_axi_wvalid  && m1_axi_wready;
  assign b_hs   = m1_axi_bvalid  && m1_axi_bready;
  assign ar_hs  = m1_axi_arvalid && m1_axi_arready;
  assign r_hs   = m1_axi_rvalid  && m1_axi_rready;
  assign any_hs = aw_hs || w_hs || b_hs || ar_hs || r_hs;

  // Any handshake opens a fresh wait phase, so only an unbroken stall can expire.
  assign expired = (TIMEOUT != 0) && !any_hs && (cnt_q == CNT_LAST);

  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
  assign done       = (state_q == S_DONE) || (state_q == S_ERR);
  assign error      = (state_q == S_ERR);
  assign sum        = sum_q;
  assign overflow   = ovf_q;
  assign resp_flags = resp_q;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    ar_done_d = ar_done_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    resp_d    = resp_q;

    if (busy && (TIMEOUT != 0)) begin
      cnt_d = any_hs ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d   = op_a;
          opb_d   = op_b;
          sum_d   = '0;
          ovf_d   = 1'b0;
          resp_d  = '0;
          state_d = S_WR_A;
        end
      end
      S_WR_A, S_WR_B: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          state_d = (state_q == S_WR_A) ? S_RESP_A : S_RESP_B;
        end else if (expired) begin
          state_d = S_ERR;
        end
      end
      S_RESP_A: begin
        if (b_hs) begin
          resp_d[0] = m1_axi_bresp;
          state_d   = S_WR_B;
        end else if (expired) begin
          state_d = S_ERR;
        end
      end
      S_RESP_B: begin
        if (b_hs) begin
          resp_d[1] = m1_axi_bresp;
          state_d   = S_RD_SUM;
        end else if (expired) begin
          state_d = S_ERR;
        end
      end
      S_RD_SUM: begin
        if (ar_hs) ar_done_d = 1'b1;
        if (r_hs) begin
          sum_d     = m1_axi_rdata;
          resp_d[2] = m1_axi_rresp;
          state_d   = S_RD_OVF;
        end else if (expired) begin
          state_d = S_ERR;
        end
      end
      S_RD_OVF: begin
        if (ar_hs) ar_done_d = 1'b1;
        if (r_hs) begin
          ovf_d     = m1_axi_rdata[0];
          resp_d[3] = m1_axi_rresp;
          state_d   = S_DONE;
        end else if (expired) begin
          state_d = S_ERR;
        end
      end
      S_DONE, S_ERR: state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase

    // Channel progress and the stall counter belong to one state; wipe them on every move.
    if (state_d != state_q) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      ar_done_d = 1'b0;
      cnt_d     = '0;
    end
  end

  // NOTE: non-blocking assignments only; the held operands reset too so wdata reads 0 out of reset.
  always_ff @(posedge m1_axi_aclk) begin
    if (m1_axi_areset) begin
      state_q   <= S_IDLE;
      opa_q     <= '0;
      opb_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ar_done_q <= 1'b0;
      cnt_q     <= '0;
      sum_q     <= '0;
      ovf_q     <= 1'b0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      ar_done_q <= ar_done_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      ovf_q     <= ovf_d;
      resp_q    <= resp_d;
    end
  end

endmodule
